// File: rtl/r_burst_rr_arbiter.sv
// AXI R-channel return arbiter: round-robin grant among NUM_SLV slaves,
// held for a whole burst until the RLAST handshake, with beat counting and overflow flag.
module r_burst_rr_arbiter #(
  parameter int NUM_SLV   = 7,
  parameter int IDS_BITS  = 8,
  parameter int DATA_BITS = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_SLV*IDS_BITS-1:0]    s_rid,
  input  logic [NUM_SLV*DATA_BITS-1:0]   s_rdata,
  input  logic [NUM_SLV*2-1:0]           s_rresp,
  input  logic [NUM_SLV-1:0]             s_rlast,
  input  logic [NUM_SLV-1:0]             s_rvalid,
  output logic [NUM_SLV-1:0]             s_rready,
  output logic [IDS_BITS-1:0]            m_rid,
  output logic [DATA_BITS-1:0]           m_rdata,
  output logic [1:0]                     m_rresp,
  output logic                           m_rlast,
  output logic                           m_rvalid,
  input  logic                           m_rready,
  output logic [NUM_SLV-1:0]             grant_oh,
  output logic                           busy,
  output logic [7:0]                     beat_cnt,
  output logic                           burst_err,
  input  logic                           err_clr
);

  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic          burst_err_q, burst_err_d;

  logic [IW-1:0] win_idx, sel_idx, next_ptr;
  logic [IW:0]   cand;
  logic          win_found, any_sel, hs;

  // Walk offsets from the far end down so the slave closest to rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_SLV-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_SLV)) cand = cand - (IW+1)'(NUM_SLV);
      if (s_rvalid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  assign sel_idx  = (state_q == BURST) ? lock_idx_q : win_idx;
  assign any_sel  = rstn & ((state_q == BURST) | win_found);
  assign next_ptr = (sel_idx == IW'(NUM_SLV-1)) ? '0 : sel_idx + 1'b1;

  always_comb begin
    grant_oh = '0;
    m_rid    = '0;
    m_rdata  = '0;
    m_rresp  = '0;
    m_rlast  = 1'b0;
    m_rvalid = 1'b0;
    if (any_sel) begin
      grant_oh[sel_idx] = 1'b1;
      m_rid    = s_rid[sel_idx*IDS_BITS +: IDS_BITS];
      m_rdata  = s_rdata[sel_idx*DATA_BITS +: DATA_BITS];
      m_rresp  = s_rresp[sel_idx*2 +: 2];
      m_rlast  = s_rlast[sel_idx];
      m_rvalid = s_rvalid[sel_idx];
    end
    s_rready = grant_oh & {NUM_SLV{m_rready}};
  end

  assign hs = m_rvalid & m_rready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = err_clr ? 1'b0 : burst_err_q;
    if (hs && !m_rlast && beat_cnt_q == 8'(MAX_BEATS-1)) burst_err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          if (hs && m_rlast) begin
            rr_ptr_d = next_ptr;
          end else begin
            // Lock even without a handshake: the stalled VALID must keep its grant.
            state_d    = BURST;
            lock_idx_d = win_idx;
            if (hs) beat_cnt_d = 8'd1;
          end
        end
      end
      BURST: begin
        if (hs) begin
          if (m_rlast) begin
            state_d    = IDLE;
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
          end else if (beat_cnt_q != 8'hFF) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign busy      = (state_q == BURST);
  assign beat_cnt  = beat_cnt_q;
  assign burst_err = burst_err_q;

endmodule

// File: tb/tb_r_burst_rr_arbiter.sv
// Directed bench for r_burst_rr_arbiter: grant order, burst lock, backpressure,
// overflow flag and mid-burst reset, with hand-computed expectations.
module tb_r_burst_rr_arbiter;
  localparam int NS = 7;
  localparam int IB = 8;
  localparam int DB = 32;
  localparam int MB = 4;

  logic              clk;
  logic              rstn;
  logic [NS*IB-1:0]  s_rid;
  logic [NS*DB-1:0]  s_rdata;
  logic [NS*2-1:0]   s_rresp;
  logic [NS-1:0]     s_rlast, s_rvalid, s_rready;
  logic [IB-1:0]     m_rid;
  logic [DB-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast, m_rvalid, m_rready;
  logic [NS-1:0]     grant_oh;
  logic              busy;
  logic [7:0]        beat_cnt;
  logic              burst_err, err_clr;

  int checks = 0;
  int errors = 0;

  r_burst_rr_arbiter #(.NUM_SLV(NS), .IDS_BITS(IB), .DATA_BITS(DB), .MAX_BEATS(MB)) dut (
    .clk(clk), .rstn(rstn),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_oh(grant_oh), .busy(busy), .beat_cnt(beat_cnt),
    .burst_err(burst_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_rvalid = '0; s_rlast = '0; m_rready = 1'b1; err_clr = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    s_rvalid = '1; s_rlast = '1; m_rready = 1'b1;
    #1;
    checks++; if (s_rready !== 7'h00) begin errors++; $display("FAIL rst_rready got %h exp %h", s_rready, 7'h00); end
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got %b exp 0", m_rvalid); end
    checks++; if (grant_oh !== 7'h00) begin errors++; $display("FAIL rst_grant got %h exp %h", grant_oh, 7'h00); end
    checks++; if (m_rid !== 8'h00 || m_rdata !== 32'h0) begin errors++; $display("FAIL rst_payload got %h/%h exp 0/0", m_rid, m_rdata); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (beat_cnt !== 8'd0) begin errors++; $display("FAIL rst_beat got %0d exp 0", beat_cnt); end
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", burst_err); end
    rstn = 1'b1; s_rvalid = '0;
    #1;
    checks++; if (grant_oh !== 7'h00 || m_rvalid !== 1'b0) begin errors++; $display("FAIL idle_nogrant got %h/%b exp 00/0", grant_oh, m_rvalid); end
    checks++; if (m_rid !== 8'h00) begin errors++; $display("FAIL idle_payload got %h exp 00", m_rid); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    s_rlast = '1; s_rvalid = 7'b0001001;
    #1;
    checks++; if (grant_oh !== 7'h01) begin errors++; $display("FAIL sim_g0 got %h exp %h", grant_oh, 7'h01); end
    checks++; if (m_rid !== 8'hA0) begin errors++; $display("FAIL sim_rid0 got %h exp %h", m_rid, 8'hA0); end
    checks++; if (s_rready !== 7'h01) begin errors++; $display("FAIL sim_rdy0 got %h exp %h", s_rready, 7'h01); end
    checks++; if (m_rdata !== 32'hC0DE0000 || m_rresp !== 2'd0) begin errors++; $display("FAIL sim_data0 got %h/%h exp C0DE0000/0", m_rdata, m_rresp); end
    tick();
    s_rvalid = 7'b0001000;
    #1;
    checks++; if (grant_oh !== 7'h08) begin errors++; $display("FAIL sim_g1 got %h exp %h", grant_oh, 7'h08); end
    checks++; if (m_rid !== 8'hA3 || m_rresp !== 2'd3) begin errors++; $display("FAIL sim_rid1 got %h/%h exp A3/3", m_rid, m_rresp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_busy got %b exp 0", busy); end
    tick();
    s_rvalid = '1;
    #1;
    checks++; if (grant_oh !== 7'h10) begin errors++; $display("FAIL sim_ptr4 got %h exp %h", grant_oh, 7'h10); end
    tick();
    s_rvalid = '0;
  endtask

  task automatic test_fairness();
    logic [NS-1:0] e;
    do_reset();
    s_rlast = '1; s_rvalid = '1;
    for (int c = 0; c < 8; c++) begin
      e = '0; e[c % NS] = 1'b1;
      #1;
      checks++; if (grant_oh !== e) begin errors++; $display("FAIL fair_grant c%0d got %h exp %h", c, grant_oh, e); end
      checks++; if (busy !== 1'b0 || m_rvalid !== 1'b1) begin errors++; $display("FAIL fair_busy c%0d got %b/%b exp 0/1", c, busy, m_rvalid); end
      tick();
    end
    s_rvalid = '0;
  endtask

  task automatic test_burst_lock();
    do_reset();
    s_rvalid = 7'h04; s_rlast = '0;
    #1;
    checks++; if (grant_oh !== 7'h04 || busy !== 1'b0) begin errors++; $display("FAIL lock_b1 got %h/%b exp 04/0", grant_oh, busy); end
    checks++; if (beat_cnt !== 8'd0) begin errors++; $display("FAIL lock_cnt0 got %0d exp 0", beat_cnt); end
    tick();
    s_rvalid = 7'h06; s_rlast = 7'h02;
    for (int b = 1; b <= 3; b++) begin
      if (b == 3) s_rlast = 7'h06;
      #1;
      checks++; if (s_rready !== 7'h04) begin errors++; $display("FAIL lock_rdy b%0d got %h exp %h", b, s_rready, 7'h04); end
      checks++; if (beat_cnt !== 8'(b)) begin errors++; $display("FAIL lock_cnt b%0d got %0d exp %0d", b, beat_cnt, b); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy b%0d got %b exp 1", b, busy); end
      tick();
    end
    s_rvalid = 7'h02;
    #1;
    checks++; if (grant_oh !== 7'h02 || s_rready !== 7'h02) begin errors++; $display("FAIL lock_next got %h/%h exp 02/02", grant_oh, s_rready); end
    checks++; if (beat_cnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL lock_end got %0d/%b exp 0/0", beat_cnt, busy); end
    tick();
    s_rvalid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    s_rlast = '1; m_rready = 1'b0; s_rvalid = 7'h20;
    #1;
    checks++; if (grant_oh !== 7'h20 || s_rready !== 7'h00) begin errors++; $display("FAIL bp_c0 got %h/%h exp 20/00", grant_oh, s_rready); end
    checks++; if (busy !== 1'b0 || m_rvalid !== 1'b1) begin errors++; $display("FAIL bp_c0st got %b/%b exp 0/1", busy, m_rvalid); end
    tick();
    s_rvalid = 7'h21;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++; if (grant_oh !== 7'h20 || m_rid !== 8'hA5) begin errors++; $display("FAIL bp_hold c%0d got %h/%h exp 20/A5", c, grant_oh, m_rid); end
      checks++; if (busy !== 1'b1 || s_rready !== 7'h00) begin errors++; $display("FAIL bp_busy c%0d got %b/%h exp 1/00", c, busy, s_rready); end
      tick();
    end
    m_rready = 1'b1;
    #1;
    checks++; if (grant_oh !== 7'h20 || s_rready !== 7'h20) begin errors++; $display("FAIL bp_go got %h/%h exp 20/20", grant_oh, s_rready); end
    tick();
    s_rvalid = 7'h01;
    #1;
    checks++; if (grant_oh !== 7'h01 || busy !== 1'b0) begin errors++; $display("FAIL bp_after got %h/%b exp 01/0", grant_oh, busy); end
    tick();
    s_rvalid = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    s_rvalid = 7'h10; s_rlast = '0;
    for (int b = 0; b < 3; b++) begin
      #1;
      checks++; if (grant_oh !== 7'h10 || beat_cnt !== 8'(b)) begin errors++; $display("FAIL ovf_beat b%0d got %h/%0d exp 10/%0d", b, grant_oh, beat_cnt, b); end
      checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL ovf_early b%0d got %b exp 0", b, burst_err); end
      tick();
    end
    err_clr = 1'b1;
    #1;
    checks++; if (beat_cnt !== 8'd3 || burst_err !== 1'b0) begin errors++; $display("FAIL ovf_b3 got %0d/%b exp 3/0", beat_cnt, burst_err); end
    tick();
    err_clr = 1'b0; s_rvalid = 7'h11;
    #1;
    checks++; if (burst_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", burst_err); end
    checks++; if (beat_cnt !== 8'd4 || s_rready !== 7'h10 || busy !== 1'b1) begin errors++; $display("FAIL ovf_hold got %0d/%h/%b exp 4/10/1", beat_cnt, s_rready, busy); end
    tick();
    s_rlast = 7'h10;
    #1;
    checks++; if (beat_cnt !== 8'd5 || s_rready !== 7'h10 || burst_err !== 1'b1) begin errors++; $display("FAIL ovf_last got %0d/%h/%b exp 5/10/1", beat_cnt, s_rready, burst_err); end
    tick();
    s_rvalid = '0; s_rlast = '0; err_clr = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || beat_cnt !== 8'd0 || burst_err !== 1'b1) begin errors++; $display("FAIL ovf_rel got %b/%0d/%b exp 0/0/1", busy, beat_cnt, burst_err); end
    tick();
    err_clr = 1'b0;
    #1;
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", burst_err); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    s_rlast = '1; s_rvalid = 7'h20;
    #1;
    checks++; if (grant_oh !== 7'h20) begin errors++; $display("FAIL rmb_s5 got %h exp 20", grant_oh); end
    tick();
    s_rvalid = 7'h08; s_rlast = '0;
    #1;
    checks++; if (grant_oh !== 7'h08) begin errors++; $display("FAIL rmb_s3 got %h exp 08", grant_oh); end
    tick();
    rstn = 1'b0;
    #1;
    checks++; if (s_rready !== 7'h00 || m_rvalid !== 1'b0 || grant_oh !== 7'h00) begin errors++; $display("FAIL rmb_forced got %h/%b/%h exp 00/0/00", s_rready, m_rvalid, grant_oh); end
    tick();
    rstn = 1'b1; s_rvalid = '0;
    #1;
    checks++; if (busy !== 1'b0 || beat_cnt !== 8'd0) begin errors++; $display("FAIL rmb_state got %b/%0d exp 0/0", busy, beat_cnt); end
    s_rvalid = 7'h48; s_rlast = '1;
    #1;
    checks++; if (grant_oh !== 7'h08) begin errors++; $display("FAIL rmb_ptr got %h exp 08", grant_oh); end
    tick();
    s_rvalid = '0;
  endtask

  initial begin
    rstn = 1'b0; s_rvalid = '0; s_rlast = '0; m_rready = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < NS; i++) begin
      s_rid[i*IB +: IB]   = 8'hA0 + 8'(i);
      s_rdata[i*DB +: DB] = 32'hC0DE0000 + 32'(i);
      s_rresp[i*2 +: 2]   = 2'(i % 4);
    end
    test_reset();
    test_simultaneous();
    test_fairness();
    test_burst_lock();
    test_backpressure();
    test_overflow();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/r_burst_rr_arbiter.md
Name: r_burst_rr_arbiter

Overview:
Read-data (R) channel return arbiter for the AXI interconnect. It merges NUM_SLV slave R channels onto one R stream that feeds the existing ID-based master decoder.
- Grants are round-robin, not fixed-priority.
- A grant is held for a whole burst, up to the RLAST handshake, so beats from different slaves never interleave.
- Tracks beats per burst and flags bursts that exceed MAX_BEATS without RLAST.

Parameters:
NUM_SLV, 7, number of slave R channels (2..16)
IDS_BITS, 8, slave-side RID width (`AXI_IDS_BITS)
DATA_BITS, 32, RDATA width (`AXI_DATA_BITS)
MAX_BEATS, 16, legal maximum beats per burst (1..255)

Ports:
clk  in  1  clock; all state updates on posedge
rstn  in  1  reset, synchronous, active-low
s_rid  in  NUM_SLV*IDS_BITS  slave RIDs; slice i belongs to slave i
s_rdata  in  NUM_SLV*DATA_BITS  slave RDATA
s_rresp  in  NUM_SLV*2  slave RRESP
s_rlast  in  NUM_SLV  slave RLAST
s_rvalid  in  NUM_SLV  slave RVALID
s_rready  out  NUM_SLV  slave RREADY
m_rid  out  IDS_BITS  merged RID
m_rdata  out  DATA_BITS  merged RDATA
m_rresp  out  2  merged RRESP
m_rlast  out  1  merged RLAST
m_rvalid  out  1  merged RVALID
m_rready  in  1  ready from the decoder/master side
grant_oh  out  NUM_SLV  one-hot grant for the current cycle; 0 when nothing is granted
busy  out  1  1 while in the BURST state
beat_cnt  out  8  handshakes completed in the current burst
burst_err  out  1  sticky length-overflow flag
err_clr  in  1  clears burst_err

Behaviour:
- Reset is sampled at posedge while rstn=0:
  - state=IDLE, rr_ptr=0, lock_idx=0, beat_cnt=0, burst_err=0.
  - While rstn=0, outputs are forced: s_rready=0, m_rvalid=0, grant_oh=0, m_* payload=0.
- Handshake (hs) = m_rvalid & m_rready for the granted slave.
- IDLE state:
  - winner = first i with s_rvalid[i]=1, searching rr_ptr, rr_ptr+1, …, NUM_SLV-1, then wrapping to 0 … rr_ptr-1.
  - Grant is combinational with zero-bubble latency: m_* = slave[winner] signals, s_rready[winner]=m_rready, grant_oh[winner]=1, all in the same cycle.
  - No valid slave: m_rvalid=0, m_* payload=0, grant_oh=0, all s_rready=0; no state change.
  - hs with s_rlast=1: stay IDLE, rr_ptr <= (winner+1) mod NUM_SLV, beat_cnt stays 0.
  - hs with s_rlast=0: go to BURST, lock_idx <= winner, beat_cnt <= 1.
  - Valid but no hs (m_rready=0): go to BURST, lock_idx <= winner, beat_cnt stays 0. Because AXI VALID must stay stable, the winner must not change on the next cycle.
- BURST state:
  - Mux fixed to lock_idx; grant_oh[lock_idx]=1 regardless of that slave's s_rvalid.
  - m_rvalid = s_rvalid[lock_idx]; s_rready[lock_idx] = m_rready.
  - All other s_rready=0, including when other slaves are valid.
  - hs with rlast=1: go to IDLE, rr_ptr <= (lock_idx+1) mod NUM_SLV, beat_cnt <= 0.
  - hs with rlast=0: beat_cnt <= beat_cnt+1, saturating at 255.
- Overflow check:
  - Condition: hs with rlast=0 while beat_cnt == MAX_BEATS-1.
  - Effect: burst_err <= 1 on the next cycle. The burst continues and the lock is still released only by RLAST.
- err_clr=1 clears burst_err next cycle. If err_clr and a new overflow occur in the same cycle, set wins.
- Non-granted s_rready are always 0. At most one s_rready is high in any cycle.
- Paths m_rready -> s_rready and s_* -> m_* are purely combinational, with no added latency.
- busy = (state==BURST).

Test Plan:
- Simultaneous single beats: rr_ptr=0, s_rvalid=0b0001001 (S0, S3), rlast=1, m_rready=1.
  -> Cycle 0: grant_oh=0x01, m_rid=S0 RID. Cycle 1: grant_oh=0x08. Afterwards rr_ptr=4.
- Fairness: all 7 slaves continuously valid, single-beat bursts, m_rready=1.
  -> Grants 0,1,2,3,4,5,6,0 over 8 consecutive cycles, no idle cycle, busy=0 throughout.
- Burst lock: S2 sends a 4-beat burst (rlast on beat 4) while S1 raises valid at beat 2.
  -> s_rready[1]=0 until after S2's RLAST hs; beat_cnt goes 1,2,3, then 0; S1 is granted on the next cycle.
- Backpressure stability: S5 valid, m_rready=0 for 3 cycles, S0 raises valid in cycle 1.
  -> grant_oh=0x20 in every cycle, busy=1 from cycle 1; S5 completes when m_rready=1.
- Overflow: MAX_BEATS=4, S4 sends 6 beats with rlast only on beat 6.
  -> burst_err=1 the cycle after the 4th hs; the lock holds until the 6th hs; err_clr pulse then gives burst_err=0.
- Reset mid-burst: rstn=0 for 1 cycle during beat 2 of an S3 burst.
  -> During that cycle s_rready=0 and m_rvalid=0; afterwards state=IDLE, rr_ptr=0, beat_cnt=0, busy=0.
